// File: rtl/bcd_stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: FSM encoding, digit limits
// and a single-digit BCD increment helper.
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    // Returns {carry, next_digit}; the digit wraps to 0 once it reaches max.
    function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic [3:0] max);
        logic [4:0] res;
        if (digit >= max) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, digit + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, slow periodic sampler and a
// rising-edge detector producing one registered pulse per accepted press.
module btn_debounce
    import bcd_stopwatch_pkg::*;
#(
    parameter int DEB_DIV = 16000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    localparam int CW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_DIV - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          sample_q, sample_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe;

    always_comb begin
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        strobe   = (cnt_q == CNT_LAST);
        cnt_d    = strobe ? '0 : cnt_q + CW'(1);
        sample_d = strobe ? sync2_q : sample_q;
        // Only a 0->1 change between consecutive samples counts as a press,
        // so glitches shorter than one sample period are ignored.
        press_d  = strobe && sync2_q && !sample_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sample_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sample_q <= sample_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// Seconds stopwatch 00..59 with start/stop and clear buttons; BCD digits
// feed the 7-segment display controller directly.
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 16000000,
    parameter int DEB_DIV = 16000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clr,
    output logic [3:0] dout0,
    output logic [3:0] dout1,
    output logic       running,
    output logic       wrap
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [1:0] btn_raw;
    logic [1:0] btn_press;
    logic       start_pulse;
    logic       clr_pulse;

    assign btn_raw     = {btn_clr, btn_start};
    assign start_pulse = btn_press[0];
    assign clr_pulse   = btn_press[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_deb
            btn_debounce #(
                .DEB_DIV (DEB_DIV)
            ) u_deb (
                .clk    (clk),
                .rst    (rst),
                .btn_in (btn_raw[gi]),
                .press  (btn_press[gi])
            );
        end
    endgenerate

    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    dout0_q, dout0_d;
    logic [3:0]    dout1_q, dout1_d;
    logic          running_q, running_d;
    logic          wrap_q, wrap_d;
    logic          tick;
    logic [4:0]    units_inc;
    logic [4:0]    tens_inc;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        dout0_d   = dout0_q;
        dout1_d   = dout1_q;
        wrap_d    = 1'b0;
        tick      = (state_q == RUN) && (presc_q == PRESC_LAST);
        units_inc = bcd_inc(dout0_q, UNITS_MAX);
        tens_inc  = bcd_inc(dout1_q, TENS_MAX);

        if (clr_pulse) begin
            // Clear dominates: any coincident start press or tick is dropped.
            state_d = IDLE;
            presc_d = '0;
            dout0_d = 4'd0;
            dout1_d = 4'd0;
        end else begin
            if (state_q == RUN) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            if (tick) begin
                dout0_d = units_inc[3:0];
                if (units_inc[4]) begin
                    dout1_d = tens_inc[3:0];
                    wrap_d  = tens_inc[4];
                end
            end
            // A start press on a tick cycle still lets the tick land first.
            if (start_pulse) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            dout0_q   <= 4'd0;
            dout1_q   <= 4'd0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign dout0   = dout0_q;
    assign dout1   = dout1_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: a time-accumulating reference model
// (elapsed run cycles -> seconds) is compared against the DUT every cycle.
module tb_bcd_stopwatch;

    localparam int CLK_DIV = 10;
    localparam int DEB_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_clr;
    logic [3:0] dout0;
    logic [3:0] dout1;
    logic       running;
    logic       wrap;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bcd_stopwatch #(
        .CLK_DIV (CLK_DIV),
        .DEB_DIV (DEB_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clr   (btn_clr),
        .dout0     (dout0),
        .dout1     (dout1),
        .running   (running),
        .wrap      (wrap)
    );

    // Reference model: m_time counts clock cycles spent running since the
    // last clear; the displayed seconds are simply m_time / CLK_DIV mod 60.
    int m_n;
    int m_state;        // 0 stopped-cleared, 1 counting, 2 paused
    int m_time;
    bit m_wrap;
    bit m_clr_on_tick;
    bit hs1, hs2, hc1, hc2;
    bit smp_s, smp_c;
    bit pul_s, pul_c;

    task automatic model_edge(input bit s, input bit c, input bit r);
        bit ps, pc, tk, strobe;
        if (r) begin
            m_n = 0; m_state = 0; m_time = 0; m_wrap = 0; m_clr_on_tick = 0;
            hs1 = 0; hs2 = 0; hc1 = 0; hc2 = 0;
            smp_s = 0; smp_c = 0; pul_s = 0; pul_c = 0;
            return;
        end
        m_n++;
        ps = pul_s;
        pc = pul_c;
        tk = (m_state == 1) && ((m_time % CLK_DIV) == CLK_DIV - 1);
        m_wrap = 0;
        m_clr_on_tick = pc && tk;
        if (pc) begin
            m_state = 0;
            m_time  = 0;
        end else begin
            if (m_state == 1) begin
                m_time++;
                if (tk && (m_time % (60 * CLK_DIV)) == 0) m_wrap = 1;
            end
            if (ps) m_state = (m_state == 1) ? 2 : 1;
        end
        // Buttons are looked at once per DEB_DIV cycles, two cycles late.
        strobe = (m_n % DEB_DIV) == 0;
        pul_s = strobe && hs2 && !smp_s;
        pul_c = strobe && hc2 && !smp_c;
        if (strobe) begin
            smp_s = hs2;
            smp_c = hc2;
        end
        hs2 = hs1; hs1 = s;
        hc2 = hc1; hc1 = c;
    endtask

    function automatic int m_digits();
        return (m_time / CLK_DIV) % 60;
    endfunction

    function automatic logic [9:0] exp_outs();
        int d;
        logic [3:0] t, u;
        d = m_digits();
        t = 4'(d / 10);
        u = 4'(d % 10);
        return {t, u, (m_state == 1), m_wrap};
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic step(input bit s, input bit c, input bit r);
        btn_start = s;
        btn_clr   = c;
        rst       = r;
        @(posedge clk);
        model_edge(s, c, r);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        checks++;
        if ({dout1, dout0, running, wrap} !== 10'd0)
            $display("FAIL reset_state: got %h expected %h", {dout1, dout0, running, wrap}, 10'd0);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_start_count();
        int rises = 0;
        int rise_cyc = -1;
        bit prev_run = 0;
        logic [9:0] e;
        for (int i = 0; i < 160; i++) begin
            step(i < 20, 0, 0);
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL start_count cyc=%0d: got %h expected %h", i, {dout1, dout0, running, wrap}, e);
            else passed++;
            if (running && !prev_run) begin
                rises++;
                rise_cyc = i;
            end
            prev_run = running;
            if (rise_cyc >= 0 && i > rise_cyc && (i - rise_cyc) % CLK_DIV == 0 && (i - rise_cyc) / CLK_DIV <= 12) begin
                checks++;
                if ({dout1, dout0} !== bcd2((i - rise_cyc) / CLK_DIV))
                    $display("FAIL start_digits N=%0d: got %h expected %h", (i - rise_cyc) / CLK_DIV, {dout1, dout0}, bcd2((i - rise_cyc) / CLK_DIV));
                else passed++;
            end
        end
        checks++;
        if (rises !== 1) $display("FAIL start_one_pulse: got %0d rises expected 1", rises);
        else passed++;
        $display("test_start_count done");
    endtask

    task automatic test_rollover();
        int wraps = 0;
        int guard = 0;
        logic [9:0] e;
        while (m_time < 60 * CLK_DIV + 15 && guard < 800) begin
            step(0, 0, 0);
            guard++;
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL rollover cyc=%0d: got %h expected %h", guard, {dout1, dout0, running, wrap}, e);
            else passed++;
            if (wrap) begin
                wraps++;
                checks++;
                if ({dout1, dout0, running} !== 9'h001)
                    $display("FAIL rollover_wrap_digits: got %h expected 001", {dout1, dout0, running});
                else passed++;
            end
        end
        checks++;
        if (wraps !== 1 || guard >= 800) $display("FAIL rollover_wrap_count: got %0d expected 1 (guard %0d)", wraps, guard);
        else passed++;
        $display("test_rollover done");
    endtask

    task automatic test_pause();
        int guard = 0;
        logic [9:0] e;
        while (m_digits() != 23 && guard < 700) begin
            step(0, 0, 0);
            guard++;
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL pause_approach: got %h expected %h", {dout1, dout0, running, wrap}, e);
            else passed++;
        end
        for (int i = 0; i < 20; i++) begin
            step(i < 6, 0, 0);
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL pause_press cyc=%0d: got %h expected %h", i, {dout1, dout0, running, wrap}, e);
            else passed++;
        end
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0);
            checks++;
            if ({dout1, dout0, running} !== {8'h23, 1'b0})
                $display("FAIL pause_hold cyc=%0d: got %h expected 046", i, {dout1, dout0, running});
            else passed++;
        end
        for (int i = 0; i < 60; i++) begin
            step(i < 6, 0, 0);
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL pause_resume cyc=%0d: got %h expected %h", i, {dout1, dout0, running, wrap}, e);
            else passed++;
        end
        checks++;
        if (running !== 1'b1) $display("FAIL pause_resumed: got running=%b expected 1", running);
        else passed++;
        $display("test_pause done");
    endtask

    task automatic test_clear_priority();
        int guard = 0;
        logic [9:0] e;
        while (m_digits() != 45 && guard < 700) begin
            step(0, 0, 0);
            guard++;
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL clrpri_approach: got %h expected %h", {dout1, dout0, running, wrap}, e);
            else passed++;
        end
        for (int i = 0; i < 20; i++) begin
            step(i < 8, i < 8, 0);
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL clrpri cyc=%0d: got %h expected %h", i, {dout1, dout0, running, wrap}, e);
            else passed++;
        end
        checks++;
        if ({dout1, dout0, running, wrap} !== 10'd0)
            $display("FAIL clrpri_final: got %h expected 000", {dout1, dout0, running, wrap});
        else passed++;
        $display("test_clear_priority done");
    endtask

    task automatic test_clear_on_tick();
        bit hit = 0;
        logic [9:0] e;
        for (int a = 0; a < 20 && !hit; a++) begin
            for (int i = 0; i < 16 + a + 12; i++) begin
                step(i < 6, (i >= 16 + a) && (i < 22 + a), 0);
                e = exp_outs();
                checks++;
                if ({dout1, dout0, running, wrap} !== e)
                    $display("FAIL clr_tick a=%0d cyc=%0d: got %h expected %h", a, i, {dout1, dout0, running, wrap}, e);
                else passed++;
                if (m_clr_on_tick) begin
                    hit = 1;
                    checks++;
                    if ({dout1, dout0, running} !== 9'h000)
                        $display("FAIL clr_tick_digits: got %h expected 000", {dout1, dout0, running});
                    else passed++;
                end
            end
        end
        checks++;
        if (!hit) $display("FAIL clr_tick_reached: got 0 expected 1");
        else passed++;
        $display("test_clear_on_tick done");
    endtask

    task automatic test_bounce();
        int rises = 0;
        bit prev_run;
        logic [9:0] e;
        prev_run = running;
        for (int i = 0; i < 50; i++) begin
            step((i < 6) ? ((i % 2) == 0) : (i < 26), 0, 0);
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL bounce cyc=%0d: got %h expected %h", i, {dout1, dout0, running, wrap}, e);
            else passed++;
            if (running && !prev_run) rises++;
            prev_run = running;
        end
        checks++;
        if (rises > 1) $display("FAIL bounce_pulses: got %0d expected at most 1", rises);
        else passed++;
        $display("test_bounce done");
    endtask

    task automatic test_reset_mid_run();
        int guard = 0;
        logic [9:0] e;
        if (m_state != 1) begin
            for (int i = 0; i < 12; i++) step(i < 6, 0, 0);
        end
        while (m_digits() != 37 && guard < 700) begin
            step(0, 0, 0);
            guard++;
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL rstrun_approach: got %h expected %h", {dout1, dout0, running, wrap}, e);
            else passed++;
        end
        checks++;
        if ({dout1, dout0, running} !== {8'h37, 1'b1})
            $display("FAIL rstrun_at37: got %h expected 06f", {dout1, dout0, running});
        else passed++;
        step(1, 1, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        checks++;
        if ({dout1, dout0, running, wrap} !== 10'd0)
            $display("FAIL rstrun_cleared: got %h expected 000", {dout1, dout0, running, wrap});
        else passed++;
        $display("test_reset_mid_run done");
    endtask

    task automatic test_random();
        bit s = 0, c = 0, r;
        logic [9:0] e;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) s = !s;
            if (c) c = ($urandom_range(0, 9) != 0);
            else   c = ($urandom_range(0, 299) == 0);
            r = ($urandom_range(0, 999) == 0);
            step(s, c, r);
            e = exp_outs();
            checks++;
            if ({dout1, dout0, running, wrap} !== e)
                $display("FAIL random cyc=%0d: got %h expected %h", i, {dout1, dout0, running, wrap}, e);
            else passed++;
        end
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1;
        btn_start = 1'b0;
        btn_clr = 1'b0;
        test_reset();
        test_start_count();
        test_rollover();
        test_pause();
        test_clear_priority();
        test_clear_on_tick();
        test_bounce();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
